instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the main control decoder. Accepts decoded instruction fields over a
//  valid/ready stream and encodes each one into a 32-bit MIPS word. Writes the
//  words to consecutive instruction-memory locations.
//  Used by bring-up and test infrastructure to load programs into the
//  single-cycle core's IMEM without a hex file.
// PARAMETERS
//  ADDR_W     8    IMEM word-address width
//  DEPTH      256  max words per load session (<= 2**ADDR_W)
//  BASE_ADDR  0    word address of the first written instruction
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   1-cycle pulse: begin (or restart) a load session
//  in_valid     in   1   field bundle valid
//  in_ready     out  1   block can accept a bundle this cycle
//  in_last      in   1   bundle is the final instruction of the program
//  in_cls       in   3   0 R-type, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 ORI, 6 J, 7 illegal
//  in_alu_op    in   4   R-type op: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  in_rs/in_rt/in_rd in 5 each  register fields
//  in_shamt     in   5   shift amount (SLL/SRL/SRA only)
//  in_imm       in   16  immediate / branch offset
//  in_target    in   26  jump target field
//  imem_we      out  1   IMEM write strobe
//  imem_addr    out  ADDR_W  IMEM word address
//  imem_wdata   out  32  encoded instruction
//  word_cnt     out  ADDR_W+1  words written this session
//  done         out  1   session complete (level)
//  full         out  1   session ended because DEPTH words were written
//  err          out  1   1-cycle pulse: illegal bundle dropped
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, all outputs 0, imem_addr=BASE_ADDR.
//  FSM states: IDLE, LOAD, DONE.
//   - IDLE/DONE + start -> LOAD; word_cnt=0; done=0; full=0.
//   - LOAD + start -> LOAD, same clears (abort and restart, nothing written that cycle).
//   - LOAD: a bundle is accepted on an edge with in_valid && in_ready.
//   - Accepted with in_last=1, or accept makes word_cnt==DEPTH -> DONE at that edge.
//   - full=1 iff exit was by count and in_last=0 on that bundle.
//   - in_last takes precedence over DEPTH when both end the session.
//  in_ready = (state==LOAD) && !start. Combinational, throughput 1 word/cycle.
//  Encoding is registered, latency 1. The bundle accepted at edge N gives
//   imem_we=1 for the cycle after N, with imem_addr=BASE_ADDR+word_cnt(old) and
//   imem_wdata=encoding. word_cnt increments at N.
//  R: {6'b0,rs,rt,rd,shamt,funct}. funct per alu_op:
//   20,22,24,25,26,00,02,03,2A,2B (hex).
//   shamt is forced to 0 for non-shift ops. rs is forced to 0 for shifts.
//  LW 0x23 / SW 0x2B / BEQ 0x04 / ADDI 0x08 / ORI 0x0D: {op,rs,rt,imm}.
//  J 0x02: {op,target}.
//  Illegal bundle (cls=7, or R-type with alu_op>9):
//   - still accepted, but no write and word_cnt unchanged;
//   - err pulses the cycle after acceptance;
//   - its in_last is still honoured (-> DONE).
//  The final word's imem_we cycle coincides with the first done=1 cycle.
//  Address arithmetic is mod 2**ADDR_W; BASE_ADDR+DEPTH may wrap.
//  imem_we is never high outside the cycle after an accepted legal bundle.
// TESTING
//  1. ADD rd=3 rs=1 rt=2 -> imem_we 1 cycle later, addr 0, wdata 0x00221820.
//  2. LW rt=8 rs=29 imm=4, then J target=0x10 with in_last
//     -> 0x8FA80004 @0, 0x08000010 @1, word_cnt=2, done=1, full=0.
//  3. SLL rd=2 rt=1 shamt=4 rs=7 -> 0x00011100 (rs forced 0).
//     ORI rt=5 imm=0xFFFF -> 0x3405FFFF. BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
//  4. cls=7, then R alu_op=12 -> err pulses twice, no imem_we,
//     word_cnt unchanged, next legal word goes to next address.
//  5. DEPTH=4, stream 6 legal words, in_last never set
//     -> 4 writes, full=1, done=1, in_ready=0 afterwards.
//  6. rst_n low mid-stream and start mid-LOAD
//     -> outputs cleared immediately / word_cnt=0, next write at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Inverse of the main control decoder. Takes decoded instruction fields over
//   a valid/ready stream, encodes each bundle into a 32-bit MIPS word and
//   writes the words to consecutive IMEM locations starting at BASE_ADDR.
//   Lets bring-up/test infrastructure load programs without a hex file.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 1-cycle pulse: begin or restart a load session
//   in_valid / in_ready   field-bundle handshake (in_ready is combinational)
//   in_last               bundle is the final instruction of the program
//   in_cls                0 R,1 LW,2 SW,3 BEQ,4 ADDI,5 ORI,6 J,7 illegal
//   in_alu_op             R-type op 0..9 (ADD..SLTU), >9 illegal
//   in_rs/rt/rd/shamt     register and shift-amount fields
//   in_imm, in_target     immediate / branch offset, jump target
//   imem_we/addr/wdata    registered IMEM write port (latency 1)
//   word_cnt              words written in the current session
//   done                  session complete (level)
//   full                  session ended because DEPTH words were written
//   err                   1-cycle pulse: an illegal bundle was dropped

module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_cls,
  input  logic [3:0]        in_alu_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_ADDI = 3'd4,
    CLS_ORI  = 3'd5,
    CLS_J    = 3'd6,
    CLS_ILL  = 3'd7
  } cls_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  cls_e              cls;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic [5:0]        funct;
  logic [4:0]        rs_f;
  logic [4:0]        sh_f;
  logic [ADDR_W:0]   cnt_inc;

  assign cls     = cls_e'(in_cls);
  assign cnt_inc = cnt_q + ONE_C;

  // Field encoder
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    funct     = '0;
    rs_f      = in_rs;
    sh_f      = in_shamt;
    case (cls)
      CLS_R: begin
        case (in_alu_op)
          4'd0:    funct = 6'h20;
          4'd1:    funct = 6'h22;
          4'd2:    funct = 6'h24;
          4'd3:    funct = 6'h25;
          4'd4:    funct = 6'h26;
          4'd5:    funct = 6'h00;
          4'd6:    funct = 6'h02;
          4'd7:    funct = 6'h03;
          4'd8:    funct = 6'h2A;
          4'd9:    funct = 6'h2B;
          default: enc_legal = 1'b0;
        endcase
        // Shifts take their operand from rt, so rs is meaningless there;
        // every other R op has no shift amount.
        if (in_alu_op inside {4'd5, 4'd6, 4'd7}) begin
          rs_f = '0;
        end else begin
          sh_f = '0;
        end
        enc_word = {6'b000000, rs_f, in_rt, in_rd, sh_f, funct};
      end
      CLS_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm};
      CLS_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm};
      CLS_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm};
      CLS_ADDI: enc_word = {6'h08, in_rs, in_rt, in_imm};
      CLS_ORI:  enc_word = {6'h0D, in_rs, in_rt, in_imm};
      CLS_J:    enc_word = {6'h02, in_target};
      default:  enc_legal = 1'b0;
    endcase
  end

  // Session control and registered write port
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (start) begin
          // Abort and restart: in_ready is low, so no bundle is taken.
          cnt_d  = '0;
          full_d = 1'b0;
        end else if (in_valid) begin
          if (enc_legal) begin
            we_d    = 1'b1;
            addr_d  = BASE_C + cnt_q[ADDR_W-1:0];
            wdata_d = enc_word;
            cnt_d   = cnt_inc;
          end else begin
            err_d = 1'b1;
          end
          // in_last wins over the depth limit, so full stays low then.
          if (in_last) begin
            state_d = S_DONE;
          end else if (enc_legal && (cnt_inc == DEPTH_C)) begin
            state_d = S_DONE;
            full_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_C;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD) && !start;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt   = cnt_q;
  assign done       = (state_q == S_DONE);
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 0;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_cls;
  logic [3:0]        in_alu_op;
  logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              done, full, err;

  instr_encoder_loader #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_cls    (in_cls),
    .in_alu_op (in_alu_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .word_cnt  (word_cnt),
    .done      (done),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  err_pending = 0;
  int  errors = 0;
  int  checks = 0;

  // Reference model of the session
  bit  m_load = 0;
  bit  m_done = 0;
  bit  m_full = 0;
  int  m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes / error pulses when the DUT presents them
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      if (imem_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected", imem_addr, imem_wdata);
        end else begin
          e = sb.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_wdata, e.data);
        end
      end
      if (err) begin
        checks++;
        if (err_pending == 0) begin
          errors++;
          $display("FAIL unexpected_err: err=1 expected 0");
        end else begin
          err_pending--;
        end
      end
    end
  end

  task automatic clear_inputs();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_cls    = '0;
    in_alu_op = '0;
    in_rs     = '0;
    in_rt     = '0;
    in_rd     = '0;
    in_shamt  = '0;
    in_imm    = '0;
    in_target = '0;
  endtask

  task automatic set_bundle(input logic [2:0] cls, input logic [3:0] op,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tgt,
                            input logic last);
    in_valid  = 1'b1;
    in_cls    = cls;
    in_alu_op = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  // One bundle per cycle; expected response pushed from the model
  task automatic send(input logic [2:0] cls, input logic [3:0] op,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input bit legal, input logic [31:0] w);
    wr_t e;
    @(negedge clk);
    set_bundle(cls, op, rs, rt, rd, sh, imm, tgt, last);
    #1;
    check("in_ready", 32'(in_ready), 32'(m_load));
    @(posedge clk);
    if (m_load) begin
      if (legal) begin
        e.addr = ADDR_W'(BASE_ADDR + m_cnt);
        e.data = w;
        sb.push_back(e);
        m_cnt++;
      end else begin
        err_pending++;
      end
      if (last) begin
        m_load = 0;
        m_done = 1;
      end else if (legal && m_cnt == DEPTH) begin
        m_load = 0;
        m_done = 1;
        m_full = 1;
      end
    end
  endtask

  // start pulse; with_bundle holds a valid bundle that must not be taken
  task automatic do_start(input bit with_bundle);
    @(negedge clk);
    start = 1'b1;
    if (with_bundle) set_bundle(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    else clear_inputs();
    #1;
    check("in_ready_during_start", 32'(in_ready), 32'd0);
    @(posedge clk);
    m_load = 1;
    m_done = 0;
    m_full = 0;
    m_cnt  = 0;
    #1;
    start = 1'b0;
    clear_inputs();
  endtask

  task automatic drain_and_check_state();
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    check("word_cnt", 32'(word_cnt), 32'(m_cnt));
    check("done", 32'(done), 32'(m_done));
    check("full", 32'(full), 32'(m_full));
    check("in_ready_idle", 32'(in_ready), 32'(m_load));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_inputs();
    #3;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ADD
    do_start(0);
    send(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 1, 32'h00221820);
    drain_and_check_state();

    // 2: LW then J with in_last
    do_start(0);
    send(3'd1, 4'd0, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0, 1, 32'h8FA80004);
    send(3'd6, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 1, 32'h08000010);
    drain_and_check_state();

    // 3: SLL (rs forced 0), ORI, BEQ
    do_start(0);
    send(3'd0, 4'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 1, 32'h00011100);
    send(3'd5, 4'd0, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1, 32'h3405FFFF);
    send(3'd3, 4'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 1, 32'h1022FFFF);
    drain_and_check_state();

    // 4: AND (shamt forced 0), two illegal bundles, SLTU at next address
    do_start(0);
    send(3'd0, 4'd2, 5'd2, 5'd3, 5'd1, 5'd7, 16'h0, 26'h0, 1'b0, 1, 32'h00430824);
    send(3'd7, 4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h1234, 26'h0, 1'b0, 0, 32'h0);
    send(3'd0, 4'd12, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 0, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("cnt_after_illegal", 32'(word_cnt), 32'd1);
    send(3'd0, 4'd9, 5'd8, 5'd9, 5'd7, 5'd0, 16'h0, 26'h0, 1'b1, 1, 32'h0109382B);
    drain_and_check_state();

    // illegal bundle carrying in_last still ends the session
    do_start(0);
    send(3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 0, 32'h0);
    drain_and_check_state();

    // 5: six ADDI words, DEPTH=4 -> four writes, full
    do_start(0);
    for (int k = 1; k <= 6; k++)
      send(3'd4, 4'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'(k), 26'h0, 1'b0, 1, 32'h20220000 | 32'(k));
    drain_and_check_state();

    // in_last on the DEPTH-th word takes precedence: full stays 0
    do_start(0);
    for (int k = 1; k <= 4; k++)
      send(3'd5, 4'd0, 5'd0, 5'd5, 5'd0, 5'd0, 16'(k), 26'h0, (k == 4), 1, 32'h34050000 | 32'(k));
    drain_and_check_state();

    // 6a: start mid-LOAD with a valid bundle present
    do_start(0);
    send(3'd2, 4'd0, 5'd4, 5'd3, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0, 1, 32'hAC830008);
    send(3'd0, 4'd1, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0, 1, 32'h00A62022);
    do_start(1);
    check("cnt_after_restart", 32'(word_cnt), 32'd0);
    send(3'd0, 4'd7, 5'd3, 5'd10, 5'd9, 5'd31, 16'h0, 26'h0, 1'b1, 1, 32'h000A4FC3);
    drain_and_check_state();

    // 6b: async reset while a write is being presented
    do_start(0);
    send(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1, 32'h00221820);
    send(3'd0, 4'd1, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0, 1, 32'h00A62022);
    #2;
    rst_n = 1'b0;
    sb.delete(sb.size() - 1);
    m_load = 0;
    m_done = 0;
    m_full = 0;
    m_cnt  = 0;
    #1;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'(BASE_ADDR));
    check("midrst_cnt", 32'(word_cnt), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    do_start(0);
    send(3'd1, 4'd0, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 1, 32'h8FA80004);
    drain_and_check_state();

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("err_pending", 32'(err_pending), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
